pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/picomips_pkg.sv | 13 +
 rtl/edge_det.sv | 26 ++
 rtl/pc_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared types and default sizes for the picoMIPS instruction fetch front end.
package picomips_pkg;

  localparam int PSIZE_DEF = 4;
  localparam int ISIZE_DEF = 20;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for an already-synchronised level input.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction register with branch, wait-for-go and halt control.
module pc_fetch
  import picomips_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Isize-1:0] I,
  output logic [Psize-1:0] address,
  output logic [Isize-1:0] ir,
  output logic [Psize-1:0] ir_pc,
  output logic             ir_valid,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             branch_abs,
  input  logic [Psize-1:0] branch_off,
  input  logic             wait_req,
  input  logic             go,
  input  logic             halt_req,
  output logic             halted,
  output logic             wrap
);

  fetch_state_e     state_q, state_d;
  logic [Psize-1:0] address_q, address_d;
  logic [Isize-1:0] ir_q, ir_d;
  logic [Psize-1:0] ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic             wrap_q, wrap_d;

  logic                    go_rise;
  logic signed [Psize-1:0] rel_target;
  logic [Psize-1:0]        br_target;

  edge_det u_go_edge (
    .clk  (clk),
    .reset(reset),
    .d    (go),
    .rise (go_rise)
  );

  // Relative targets are signed offsets from the branching instruction, wrapping in Psize bits.
  always_comb begin
    rel_target = $signed(ir_pc_q) + $signed(branch_off);
    br_target  = branch_abs ? branch_off : $unsigned(rel_target);
  end

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    wrap_d     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ir_valid_q && halt_req) begin
          state_d    = ST_HALT;
          ir_valid_d = 1'b0;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (ir_valid_q && branch_en) begin
          // Drop the fall-through fetch; the target is fetched next cycle.
          address_d  = br_target;
          ir_valid_d = 1'b0;
        end else if (ir_valid_q && wait_req) begin
          state_d = ST_WAIT;
        end else begin
          address_d  = address_q + Psize'(1);
          ir_d       = I;
          ir_pc_d    = address_q;
          ir_valid_d = 1'b1;
          wrap_d     = (address_q == '1);
        end
      end
      ST_WAIT: begin
        // Retire the waiting instruction; fetch resumes at the held address.
        if (go_rise) begin
          state_d    = ST_RUN;
          ir_valid_d = 1'b0;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      address_q  <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign address  = address_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == ST_HALT);
  assign wrap     = wrap_q;

endmodule
